// File: rtl/lcd_i2c_responder_if.sv
// Parallel-side bundle of the PCF8574-style I2C responder: read-back port,
// written port image and the LCD nibble capture outputs.
`timescale 1ns/1ps
interface lcd_i2c_responder_if;
    localparam int unsigned DATA_W = 8;
    localparam int unsigned NIB_W  = 4;

    logic [DATA_W-1:0] port_in;
    logic [DATA_W-1:0] port_data;
    logic              port_valid;
    logic [NIB_W-1:0]  lcd_nibble;
    logic              lcd_rs;
    logic              lcd_nib_valid;
    logic              busy;

    modport slave (
        input  port_in,
        output port_data, port_valid, lcd_nibble, lcd_rs, lcd_nib_valid, busy
    );

    modport master (
        output port_in,
        input  port_data, port_valid, lcd_nibble, lcd_rs, lcd_nib_valid, busy
    );
endinterface

// File: rtl/lcd_i2c_responder.sv
// I2C target emulating a PCF8574 port expander driving an HD44780 LCD in
// 4-bit mode; captures the data nibble on each falling edge of the EN bit.
`timescale 1ns/1ps
module lcd_i2c_responder #(
    parameter logic [6:0] I2C_ADDR = 7'h27
) (
    input  logic clk,
    input  logic rst,
    input  logic scl,
    inout  wire  sda,
    lcd_i2c_responder_if.slave bus
);
    localparam int unsigned DATA_W = 8;
    localparam int unsigned NIB_W  = 4;
    localparam int unsigned CNT_W  = 4;

    typedef enum logic [2:0] {
        IDLE, ADDR, ADDR_ACK, WR, WR_ACK, RD, RD_ACK, IGNORE
    } state_t;

    state_t state, state_n;

    logic [1:0]        scl_sync, sda_sync;
    logic              scl_d, sda_d;
    logic              scl_s, sda_s;
    logic              scl_rise, scl_fall, start_c, stop_c;

    logic [CNT_W-1:0]  cnt, cnt_n;
    logic [DATA_W-1:0] shift, shift_n;
    logic [DATA_W-1:0] new_byte;
    logic              sda_low, sda_low_n;
    logic              busy_q, busy_n;
    logic [DATA_W-1:0] data_q, data_n;
    logic              valid_q, valid_n;
    logic [NIB_W-1:0]  nibble_q, nibble_n;
    logic              rs_q, rs_n;
    logic              nib_valid_q, nib_valid_n;

    // Open-drain: only ever pull low
    assign sda = sda_low ? 1'b0 : 1'bz;

    assign scl_s    = scl_sync[1];
    assign sda_s    = sda_sync[1];
    assign scl_rise = scl_s & ~scl_d;
    assign scl_fall = ~scl_s & scl_d;
    assign start_c  = scl_s & scl_d & sda_d & ~sda_s;
    assign stop_c   = scl_s & scl_d & ~sda_d & sda_s;

    assign bus.port_data     = data_q;
    assign bus.port_valid    = valid_q;
    assign bus.lcd_nibble    = nibble_q;
    assign bus.lcd_rs        = rs_q;
    assign bus.lcd_nib_valid = nib_valid_q;
    assign bus.busy          = busy_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            scl_sync    <= 2'b11;
            sda_sync    <= 2'b11;
            scl_d       <= 1'b1;
            sda_d       <= 1'b1;
            state       <= IDLE;
            cnt         <= '0;
            shift       <= '0;
            sda_low     <= 1'b0;
            busy_q      <= 1'b0;
            data_q      <= 8'hFF;
            valid_q     <= 1'b0;
            nibble_q    <= '0;
            rs_q        <= 1'b0;
            nib_valid_q <= 1'b0;
        end else begin
            scl_sync    <= {scl_sync[0], scl};
            sda_sync    <= {sda_sync[0], sda};
            scl_d       <= scl_s;
            sda_d       <= sda_s;
            state       <= state_n;
            cnt         <= cnt_n;
            shift       <= shift_n;
            sda_low     <= sda_low_n;
            busy_q      <= busy_n;
            data_q      <= data_n;
            valid_q     <= valid_n;
            nibble_q    <= nibble_n;
            rs_q        <= rs_n;
            nib_valid_q <= nib_valid_n;
        end
    end

    always_comb begin
        state_n     = state;
        cnt_n       = cnt;
        shift_n     = shift;
        sda_low_n   = sda_low;
        busy_n      = busy_q;
        data_n      = data_q;
        valid_n     = 1'b0;
        nibble_n    = nibble_q;
        rs_n        = rs_q;
        nib_valid_n = 1'b0;
        new_byte    = {shift[DATA_W-2:0], sda_s};

        if (start_c) begin
            state_n   = ADDR;
            cnt_n     = '0;
            shift_n   = '0;
            sda_low_n = 1'b0;
            busy_n    = 1'b0;
        end else if (stop_c) begin
            state_n   = IDLE;
            cnt_n     = '0;
            sda_low_n = 1'b0;
            busy_n    = 1'b0;
        end else begin
            case (state)
                ADDR: if (scl_rise) begin
                    shift_n = new_byte;
                    cnt_n   = cnt + CNT_W'(1);
                    if (cnt == CNT_W'(7)) begin
                        cnt_n   = '0;
                        state_n = (shift[6:0] == I2C_ADDR) ? ADDR_ACK : IGNORE;
                    end
                end
                // First fall after the 8th bit starts the ACK, the next one ends it
                ADDR_ACK: if (scl_fall) begin
                    if (!sda_low) begin
                        sda_low_n = 1'b1;
                        busy_n    = 1'b1;
                    end else if (shift[0]) begin
                        state_n   = RD;
                        shift_n   = bus.port_in;
                        sda_low_n = ~bus.port_in[DATA_W-1];
                        cnt_n     = CNT_W'(1);
                    end else begin
                        state_n   = WR;
                        sda_low_n = 1'b0;
                    end
                end
                WR: if (scl_rise) begin
                    shift_n = new_byte;
                    cnt_n   = cnt + CNT_W'(1);
                    if (cnt == CNT_W'(7)) begin
                        cnt_n   = '0;
                        state_n = WR_ACK;
                        data_n  = new_byte;
                        valid_n = 1'b1;
                        // EN falling edge latches the nibble the LCD would see
                        if (data_q[2] && !new_byte[2]) begin
                            nibble_n    = data_q[7:4];
                            rs_n        = data_q[0];
                            nib_valid_n = 1'b1;
                        end
                    end
                end
                WR_ACK: if (scl_fall) begin
                    if (!sda_low) begin
                        sda_low_n = 1'b1;
                    end else begin
                        sda_low_n = 1'b0;
                        state_n   = WR;
                    end
                end
                RD: if (scl_fall) begin
                    if (cnt == CNT_W'(8)) begin
                        sda_low_n = 1'b0;
                        cnt_n     = '0;
                        state_n   = RD_ACK;
                    end else begin
                        shift_n   = {shift[DATA_W-2:0], 1'b0};
                        sda_low_n = ~shift[DATA_W-2];
                        cnt_n     = cnt + CNT_W'(1);
                    end
                end
                // A fall here can only follow an ACKed 9th rise
                RD_ACK: begin
                    if (scl_rise && sda_s) begin
                        state_n = IGNORE;
                    end else if (scl_fall) begin
                        state_n   = RD;
                        shift_n   = bus.port_in;
                        sda_low_n = ~bus.port_in[DATA_W-1];
                        cnt_n     = CNT_W'(1);
                    end
                end
                IDLE, IGNORE: sda_low_n = 1'b0;
                default: begin
                    state_n   = IDLE;
                    sda_low_n = 1'b0;
                end
            endcase
        end
    end
endmodule
